// File: rtl/test_ctrl_pkg.sv
// Shared definitions for the test-window sequencer: state codes, default
// counter widths and the fixed length of the counter-clear phase.
package test_ctrl_pkg;

    localparam int WIN_W_DEF    = 24;
    localparam int SET_W_DEF    = 8;
    localparam int CLEAR_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_SETTLE   = 3'd2,
        S_RUN      = 3'd3,
        S_SNAP     = 3'd4,
        S_WAIT_ACK = 3'd5
    } state_t;

endpackage

// File: rtl/test_window_seq_sync.sv
// Two-flop synchronizer for an RPi control line, with an optional registered
// one-cycle pulse on the synchronized rising edge.
module pi_sync #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_sync = EDGE ? r_pulse : r_sync;

endmodule

// File: rtl/test_window_seq.sv
// Test-window sequencer: on an RPi START it clears the counters, waits a settle
// delay, gates counting for a window, snapshots, then waits for readout ACK.
module test_window_seq
    import test_ctrl_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int SET_W = SET_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic             START,
    input  logic             ABORT,
    input  logic             ACK,
    input  logic [WIN_W-1:0] WIN_LEN,
    input  logic [SET_W-1:0] SETTLE_LEN,
    output logic             CNT_CLR,
    output logic             CNT_EN,
    output logic             SNAP,
    output logic             RDY,
    output logic             BUSY,
    output logic             OVR,
    output logic             ABORTED,
    output logic [2:0]       STATE
);

    localparam int CNT_W = (WIN_W > SET_W) ? WIN_W : SET_W;

    logic w_start;
    logic w_abort;
    logic w_ack;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] w_win_next;
    logic [SET_W-1:0] r_set;
    logic [SET_W-1:0] w_set_next;
    logic             r_ovr;
    logic             w_ovr_next;
    logic             r_aborted;
    logic             w_aborted_next;
    logic             r_cnt_clr;
    logic             r_cnt_en;
    logic             r_snap;
    logic             r_rdy;
    logic             r_busy;

    pi_sync #(.EDGE(1'b1)) u_start_sync (
        .clk     (CLK),
        .rst_n   (RST_B),
        .i_async (START),
        .o_sync  (w_start)
    );

    pi_sync #(.EDGE(1'b0)) u_abort_sync (
        .clk     (CLK),
        .rst_n   (RST_B),
        .i_async (ABORT),
        .o_sync  (w_abort)
    );

    pi_sync #(.EDGE(1'b1)) u_ack_sync (
        .clk     (CLK),
        .rst_n   (RST_B),
        .i_async (ACK),
        .o_sync  (w_ack)
    );

    // Down-counter fires on 1 and is reloaded for the next phase, so it never wraps.
    always_comb begin
        w_next         = r_state;
        w_cnt_next     = r_cnt;
        w_win_next     = r_win;
        w_set_next     = r_set;
        w_ovr_next     = r_ovr;
        w_aborted_next = r_aborted;

        if (w_start && (r_state != S_IDLE)) begin
            w_ovr_next = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_start && !w_abort) begin
                    w_next         = S_CLEAR;
                    w_win_next     = (WIN_LEN == '0) ? WIN_W'(1) : WIN_LEN;
                    w_set_next     = SETTLE_LEN;
                    w_ovr_next     = 1'b0;
                    w_aborted_next = 1'b0;
                    w_cnt_next     = CNT_W'(CLEAR_CYCLES);
                end
            end
            S_CLEAR: begin
                if (r_cnt == CNT_W'(1)) begin
                    if (r_set == '0) begin
                        w_next     = S_RUN;
                        w_cnt_next = CNT_W'(r_win);
                    end else begin
                        w_next     = S_SETTLE;
                        w_cnt_next = CNT_W'(r_set);
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next     = S_RUN;
                    w_cnt_next = CNT_W'(r_win);
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next     = S_SNAP;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_SNAP: begin
                w_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (w_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase

        if (w_abort && (r_state != S_IDLE)) begin
            w_next         = S_IDLE;
            w_cnt_next     = '0;
            w_aborted_next = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they switch together with STATE.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_win     <= '0;
            r_set     <= '0;
            r_ovr     <= 1'b0;
            r_aborted <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_cnt_en  <= 1'b0;
            r_snap    <= 1'b0;
            r_rdy     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_win     <= w_win_next;
            r_set     <= w_set_next;
            r_ovr     <= w_ovr_next;
            r_aborted <= w_aborted_next;
            r_cnt_clr <= (w_next == S_CLEAR);
            r_cnt_en  <= (w_next == S_RUN);
            r_snap    <= (w_next == S_SNAP);
            r_rdy     <= (w_next == S_WAIT_ACK);
            r_busy    <= (w_next != S_IDLE);
        end
    end

    assign CNT_CLR = r_cnt_clr;
    assign CNT_EN  = r_cnt_en;
    assign SNAP    = r_snap;
    assign RDY     = r_rdy;
    assign BUSY    = r_busy;
    assign OVR     = r_ovr;
    assign ABORTED = r_aborted;
    assign STATE   = r_state;

endmodule

// File: tb/tb_test_window_seq.sv
// Self-checking bench for test_window_seq: directed and randomized windows
// compared cycle by cycle against a timeline model of the sequencer.
module tb_test_window_seq;

    localparam int WIN_W = 24;
    localparam int SET_W = 8;

    logic             CLK;
    logic             RST_B;
    logic             START;
    logic             ABORT;
    logic             ACK;
    logic [WIN_W-1:0] WIN_LEN;
    logic [SET_W-1:0] SETTLE_LEN;
    logic             CNT_CLR;
    logic             CNT_EN;
    logic             SNAP;
    logic             RDY;
    logic             BUSY;
    logic             OVR;
    logic             ABORTED;
    logic [2:0]       STATE;

    int compared;
    int mismatched;
    logic prevOvr;
    logic prevAborted;

    test_window_seq #(.WIN_W(WIN_W), .SET_W(SET_W)) dut (
        .CLK        (CLK),
        .RST_B      (RST_B),
        .START      (START),
        .ABORT      (ABORT),
        .ACK        (ACK),
        .WIN_LEN    (WIN_LEN),
        .SETTLE_LEN (SETTLE_LEN),
        .CNT_CLR    (CNT_CLR),
        .CNT_EN     (CNT_EN),
        .SNAP       (SNAP),
        .RDY        (RDY),
        .BUSY       (BUSY),
        .OVR        (OVR),
        .ABORTED    (ABORTED),
        .STATE      (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [9:0] observed();
        return {CNT_CLR, CNT_EN, SNAP, RDY, BUSY, OVR, ABORTED, STATE};
    endfunction

    // Expected output word for a phase (0 idle, 1 clear, 2 settle, 3 run, 4 snap, 5 wait-ack).
    function automatic logic [9:0] mk(input int ph, input logic ovr, input logic ab);
        logic [2:0] code;
        code = 3'(ph);
        return {ph == 1, ph == 3, ph == 4, ph == 5, ph != 0, ovr, ab, code};
    endfunction

    task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One window, edge 1 being the first edge that samples START high.
    task automatic applyStimulus(input string tag, input int win, input int settle,
                                 input int hold, input int ackDelay, input bit ackEarly,
                                 input int abortEdge, input int ovrEdge);
        int wp, r0, sn, ae, ie, lastEdge, ph, enCount, snapCount, enExp, snapExp;
        logic expOvr, expAb;
        wp = (win == 0) ? 1 : win;
        r0 = 6 + settle;
        sn = r0 + wp;
        ae = ackEarly ? sn + 3 + ackDelay : sn + 1 + ackDelay;
        ie = ae + 3;
        lastEdge = (abortEdge != 0) ? abortEdge + 6 : ie + 2;
        enCount = 0;
        snapCount = 0;
        expOvr = prevOvr;
        expAb = prevAborted;
        WIN_LEN = WIN_W'(win);
        SETTLE_LEN = SET_W'(settle);
        for (int n = 1; n <= lastEdge; n++) begin
            START = (n <= hold) || (n == ovrEdge);
            ABORT = (abortEdge != 0) && (n >= abortEdge) && (n < abortEdge + 4);
            ACK = (abortEdge == 0) &&
                  ((ackEarly && n >= sn - 2 && n <= sn + 1) || (n >= ae && n < ae + 3));
            @(posedge CLK);
            #1;
            if (n == 4) begin
                WIN_LEN = WIN_W'($urandom);
                SETTLE_LEN = SET_W'($urandom);
            end
            if (abortEdge != 0 && n >= abortEdge + 2) ph = 0;
            else if (n < 4)  ph = 0;
            else if (n < 6)  ph = 1;
            else if (n < r0) ph = 2;
            else if (n < sn) ph = 3;
            else if (n == sn) ph = 4;
            else if (n < ie) ph = 5;
            else ph = 0;
            expOvr = (n < 4) ? prevOvr : ((ovrEdge != 0) && (n >= ovrEdge + 3));
            expAb = (n < 4) ? prevAborted : ((abortEdge != 0) && (n >= abortEdge + 2));
            checkOutput($sformatf("%s@%0d", tag, n), observed(), mk(ph, expOvr, expAb));
            enCount += int'(CNT_EN);
            snapCount += int'(SNAP);
        end
        START = 1'b0;
        ABORT = 1'b0;
        ACK = 1'b0;
        if (abortEdge != 0) begin
            enExp = ((abortEdge + 2 < r0 + wp) ? abortEdge + 2 : r0 + wp) - r0;
            if (enExp < 0) enExp = 0;
            snapExp = (abortEdge + 2 <= sn) ? 0 : 1;
        end else begin
            enExp = wp;
            snapExp = 1;
        end
        checkCount({tag, "_en_cycles"}, enCount, enExp);
        checkCount({tag, "_snap_cycles"}, snapCount, snapExp);
        prevOvr = expOvr;
        prevAborted = expAb;
    endtask

    task automatic resetMidWindow(input string tag, input int settle, input int resetEdge);
        int ph;
        WIN_LEN = WIN_W'(30);
        SETTLE_LEN = SET_W'(settle);
        for (int n = 1; n <= resetEdge; n++) begin
            START = (n == 1) || (n == 6);
            @(posedge CLK);
            #1;
        end
        START = 1'b0;
        ph = (resetEdge < 6 + settle) ? 2 : 3;
        checkOutput({tag, "_before"}, observed(), mk(ph, 1'b1, 1'b0));
        RST_B = 1'b0;
        #1;
        checkOutput({tag, "_async"}, observed(), 10'b0);
        @(posedge CLK);
        #1;
        checkOutput({tag, "_held"}, observed(), 10'b0);
        RST_B = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(posedge CLK);
            #1;
            checkOutput($sformatf("%s_after@%0d", tag, n), observed(), mk(0, 1'b0, 1'b0));
        end
        prevOvr = 1'b0;
        prevAborted = 1'b0;
    endtask

    initial begin
        int win, settle, sn, ab, ov, hi;
        compared = 0;
        mismatched = 0;
        prevOvr = 1'b0;
        prevAborted = 1'b0;
        RST_B = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        ACK = 1'b0;
        WIN_LEN = '0;
        SETTLE_LEN = '0;

        $display("[TB] reset checks");
        @(posedge CLK);
        #1;
        checkOutput("reset_held", observed(), 10'b0);
        @(posedge CLK);
        #1;
        RST_B = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("reset_release", observed(), mk(0, 1'b0, 1'b0));

        $display("[TB] basic window 10/3");
        applyStimulus("basic", 10, 3, 1, 2, 1'b0, 0, 0);

        $display("[TB] zero lengths");
        applyStimulus("zero", 0, 0, 2, 0, 1'b0, 0, 0);

        $display("[TB] abort at run cycle 5");
        applyStimulus("abort", 10, 4, 1, 0, 1'b0, 6 + 4 + 5, 0);

        $display("[TB] second start during run");
        applyStimulus("ovr", 12, 2, 3, 1, 1'b0, 0, 6 + 2 + 3);
        applyStimulus("ovr_clear", 5, 1, 1, 0, 1'b0, 0, 0);

        $display("[TB] ack coinciding with snap");
        applyStimulus("ack_snap", 6, 2, 1, 1, 1'b1, 0, 0);

        $display("[TB] randomized windows");
        for (int k = 0; k < 10; k++) begin
            win = $urandom_range(0, 25);
            settle = $urandom_range(0, 12);
            sn = 6 + settle + ((win == 0) ? 1 : win);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(5, sn + 1) : 0;
            hi = (ab != 0) ? ab - 1 : sn;
            ov = ($urandom_range(0, 1) == 1 && hi >= 5) ? $urandom_range(5, hi) : 0;
            applyStimulus($sformatf("rand%0d", k), win, settle, $urandom_range(1, 3),
                          $urandom_range(0, 4), 1'($urandom_range(0, 1)), ab, ov);
        end

        $display("[TB] reset mid-window");
        resetMidWindow("rst_settle", 20, 15);
        resetMidWindow("rst_run", 2, 12);

        $display("[TB] start and abort together in idle");
        START = 1'b1;
        ABORT = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge CLK);
            #1;
            if (n == 2) START = 1'b0;
            if (n == 8) ABORT = 1'b0;
            checkOutput($sformatf("start_abort@%0d", n), observed(), mk(0, prevOvr, prevAborted));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
